char_writer: RTL and testbench
==============================

CHAR_WRITER -- requirements
Module: char_writer

Interface
REQ-001 Parameter FIFO_DEPTH, default 8: command FIFO entries (power of two, 2..64).
REQ-002 Parameter NUM_CELLS, default 1000: character cells swept by a clear (1..1024).
REQ-003 Parameter FILL_CHAR, default 8'h20: data written to every cell during a clear.
REQ-004 clock  in  1  single clock; all logic on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 cmd_valid  in  1  write command offered.
REQ-007 cmd_ready  out  1  FIFO can accept; a transfer occurs when cmd_valid and cmd_ready are both high on a rising edge.
REQ-008 cmd_addr  in  10  target cell address.
REQ-009 cmd_data  in  8  character code.
REQ-010 clear_start  in  1  one-cycle pulse requesting a full-screen clear.
REQ-011 busy  out  1  high while the FIFO is non-empty, a write is unacknowledged, or a clear is active.
REQ-012 instructionNum  out  10  write sequence tag; a change from instructionPrev marks a new write.
REQ-013 instructionAddr  out  10  cell address of the current write.
REQ-014 instructionData  out  8  character code of the current write.
REQ-015 instructionPrev  in  10  last tag taken by the display stage; equality with instructionNum is the acknowledge.

Function
REQ-016 Command FIFO of FIFO_DEPTH entries, each {addr, data}; cmd_ready = !full, registered and free of any combinational path from cmd_valid.
REQ-017 FIFO rules: a push when full is impossible (cmd_ready low); pop and push in the same cycle keep the count unchanged; no bypass, so the minimum latency from push to issue is 1 cycle.
REQ-018 State machine IDLE, WAIT_ACK, CLEAR.
REQ-019 IDLE transitions: with a clear pending, load clear_addr=0 and go to CLEAR; else with the FIFO non-empty and instructionPrev==instructionNum, pop one entry, drive Addr/Data, increment Num, and go to WAIT_ACK; else stay.
REQ-020 WAIT_ACK: hold Num/Addr/Data stable; return to IDLE the cycle after instructionPrev==instructionNum is sampled.
REQ-021 CLEAR: issue {clear_addr, FILL_CHAR} using the same tag/acknowledge protocol; after acknowledge, clear_addr increments; after cell NUM_CELLS-1 is acknowledged, return to IDLE.
REQ-022 A clear never interrupts an unacknowledged write; FIFO commands wait until the clear completes.
REQ-023 Num increments modulo 1024; 1023 wraps to 0.
REQ-024 At most one write is outstanding at any time.
REQ-025 A clear_start pulse while a clear is pending or active is ignored; a pulse during WAIT_ACK sets clear-pending.
REQ-026 A stalled consumer (instructionPrev never matching) holds the block in WAIT_ACK indefinitely, with outputs stable.

Reset
REQ-027 When reset_n is low: instructionNum=0, instructionAddr=0, instructionData=0, FIFO empty, cmd_ready=1 after release, busy=0, state=IDLE, clear-pending=0.
REQ-028 Reset mid-write or mid-clear abandons all work; no partial state survives.

Configuration
REQ-029 Macro CHAR_WRITER_CLEAR_EN.
REQ-030 With CHAR_WRITER_CLEAR_EN defined, the clear engine, clear_start, and the CLEAR state exist as specified above.
REQ-031 With CHAR_WRITER_CLEAR_EN undefined, the clear_start port remains but is ignored, the CLEAR state and clear counter are absent, and busy reflects only FIFO and write activity.

Verification
REQ-032 Single write: push {addr 5, data 8'h41} with instructionPrev following Num one cycle later -> Num 0->1, Addr=5, Data=8'h41, busy falls after the acknowledge.
REQ-033 Burst and full: push 9 commands back-to-back with the acknowledge withheld -> cmd_ready low after the 8th accepted command; releasing the acknowledge drains all 8 in push order, with Num ending at 8.
REQ-034 Wrap: preset 1023 prior writes, then one more write -> Num=0 and the acknowledge still works.
REQ-035 Clear (macro on): clear_start with NUM_CELLS=4 -> writes to addr 0,1,2,3 with data 8'h20, then a queued command issues.
REQ-036 Clear during write: clear_start in WAIT_ACK -> the pending write completes first, then the clear starts at addr 0; a second pulse mid-clear produces no extra sweep.
REQ-037 Reset: assert reset_n low in the middle of a clear -> outputs are 0, the FIFO is empty, and no further writes occur after release.

Source files
------------

// File: rtl/char_writer_if.sv
// ---------------------------------------------------------------------------
// char_writer_if -- command bus into the character writer.
//   cmd_valid  producer offers a write command
//   cmd_ready  writer can accept (transfer when both high on a rising edge)
//   cmd_addr   target character cell address
//   cmd_data   character code
// Modports: master = command producer, slave = char_writer.
// ---------------------------------------------------------------------------
interface char_writer_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [9:0] cmd_addr;
   logic [7:0] cmd_data;

   modport master (output cmd_valid, output cmd_addr, output cmd_data, input cmd_ready);
   modport slave  (input cmd_valid, input cmd_addr, input cmd_data, output cmd_ready);
endinterface

// File: rtl/char_writer.sv
// ---------------------------------------------------------------------------
// char_writer -- buffers character-cell write commands and issues them one at
// a time to a display stage using a tag/acknowledge protocol, with an optional
// full-screen clear engine.
//
// Ports:
//   clock, reset_n        single rising-edge clock, async active-low reset
//   cmd                   char_writer_if.slave command bus (valid/ready/addr/data)
//   clear_start           one-cycle pulse requesting a full-screen clear
//   busy                  FIFO non-empty, write outstanding, or clear pending/active
//   instructionNum        write sequence tag; a change marks a new write
//   instructionAddr/Data  cell address / character of the current write
//   instructionPrev       last tag taken by the display stage (equal = acknowledge)
//
// Configuration: define CHAR_WRITER_CLEAR_EN to build the clear engine. When it
// is undefined, clear_start is present but ignored and no CLEAR state exists.
// ---------------------------------------------------------------------------
module char_writer #(
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned NUM_CELLS  = 1000,
   parameter logic [7:0]  FILL_CHAR  = 8'h20
) (
   input  logic         clock,
   input  logic         reset_n,
   char_writer_if.slave cmd,
   input  logic         clear_start,
   output logic         busy,
   output logic [9:0]   instructionNum,
   output logic [9:0]   instructionAddr,
   output logic [7:0]   instructionData,
   input  logic [9:0]   instructionPrev
);

   localparam int unsigned ADDR_W = 10;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned TAG_W  = 10;
   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W  = PTR_W + 1;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } cmd_t;

`ifdef CHAR_WRITER_CLEAR_EN
   typedef enum logic [1:0] {IDLE = 2'd0, WAIT_ACK = 2'd1, CLEAR = 2'd2} state_t;
   localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(NUM_CELLS - 1);
`else
   typedef enum logic [1:0] {IDLE = 2'd0, WAIT_ACK = 2'd1} state_t;
`endif

   // ---------------- command FIFO ----------------
   cmd_t              fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              cmd_ready_q;
   logic              push, pop;
   logic              fifo_empty;
   cmd_t              head;

   assign cmd.cmd_ready = cmd_ready_q;
   assign push          = cmd.cmd_valid && cmd_ready_q;
   assign fifo_empty    = (count_q == '0);
   assign head          = fifo_mem[rd_ptr_q];
   assign count_d       = count_q + CNT_W'(push) - CNT_W'(pop);

   // Storage array: no reset needed, occupancy is tracked by count_q.
   always_ff @(posedge clock) begin
      if (push) fifo_mem[wr_ptr_q] <= {cmd.cmd_addr, cmd.cmd_data};
   end

   // Pointers, occupancy and registered ready (derived from next occupancy).
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         cmd_ready_q <= 1'b1;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q     <= count_d;
         cmd_ready_q <= (count_d != CNT_W'(FIFO_DEPTH));
      end
   end

   // ---------------- issue state machine ----------------
   state_t            state_q, state_d;
   logic [TAG_W-1:0]  num_q, num_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              busy_q, busy_d;
   logic              ack;

   assign ack             = (instructionPrev == num_q);
   assign instructionNum  = num_q;
   assign instructionAddr = addr_q;
   assign instructionData = data_q;
   assign busy            = busy_q;

`ifdef CHAR_WRITER_CLEAR_EN
   logic              clear_pend_q, clear_pend_d;
   logic [ADDR_W-1:0] clear_addr_q, clear_addr_d;
`else
   logic              unused_clear_start;
   logic [17:0]       unused_cfg;
   assign unused_clear_start = clear_start;
   assign unused_cfg         = {FILL_CHAR, ADDR_W'(NUM_CELLS - 1)};
`endif

   // Next-state and write issue; a new write is always accompanied by a tag bump.
   always_comb begin
      state_d = state_q;
      num_d   = num_q;
      addr_d  = addr_q;
      data_d  = data_q;
      pop     = 1'b0;
`ifdef CHAR_WRITER_CLEAR_EN
      clear_pend_d = clear_pend_q;
      clear_addr_d = clear_addr_q;
      // Pulses are dropped while a clear is already pending or sweeping.
      if (clear_start && !clear_pend_q && (state_q != CLEAR)) clear_pend_d = 1'b1;
`endif
      case (state_q)
         IDLE: begin
`ifdef CHAR_WRITER_CLEAR_EN
            if (clear_pend_q) begin
               clear_pend_d = 1'b0;
               clear_addr_d = '0;
               num_d        = num_q + TAG_W'(1);
               addr_d       = '0;
               data_d       = FILL_CHAR;
               state_d      = CLEAR;
            end else
`endif
            if (!fifo_empty && ack) begin
               pop     = 1'b1;
               num_d   = num_q + TAG_W'(1);
               addr_d  = head.addr;
               data_d  = head.data;
               state_d = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            if (ack) state_d = IDLE;
         end
`ifdef CHAR_WRITER_CLEAR_EN
         // Each acknowledged cell immediately issues the next one.
         CLEAR: begin
            if (ack) begin
               if (clear_addr_q == LAST_CELL) begin
                  state_d = IDLE;
               end else begin
                  clear_addr_d = clear_addr_q + ADDR_W'(1);
                  num_d        = num_q + TAG_W'(1);
                  addr_d       = clear_addr_q + ADDR_W'(1);
                  data_d       = FILL_CHAR;
               end
            end
         end
`endif
         default: state_d = IDLE;
      endcase

      busy_d = (count_d != '0) || (state_d != IDLE);
`ifdef CHAR_WRITER_CLEAR_EN
      busy_d = busy_d || clear_pend_d;
`endif
   end

   // State and output registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         num_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         num_q   <= num_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         busy_q  <= busy_d;
      end
   end

`ifdef CHAR_WRITER_CLEAR_EN
   // Clear engine registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         clear_pend_q <= 1'b0;
         clear_addr_q <= '0;
      end else begin
         clear_pend_q <= clear_pend_d;
         clear_addr_q <= clear_addr_d;
      end
   end
`endif

endmodule

// File: tb/tb_char_writer.sv
// ---------------------------------------------------------------------------
// tb_char_writer -- scoreboard bench for char_writer. Expected writes are
// queued as commands are accepted (or clears requested); a monitor pops and
// compares every new write tag the DUT presents. A consumer process plays the
// display stage, acknowledging after a random delay.
// ---------------------------------------------------------------------------
module tb_char_writer;
   localparam int unsigned DEPTH  = 8;
   localparam int unsigned NCELLS = 4;
   localparam logic [7:0]  FILL   = 8'h20;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       clear_start;
   logic       busy;
   logic [9:0] instructionNum, instructionAddr, instructionPrev;
   logic [7:0] instructionData;

   char_writer_if cw_if ();

   char_writer #(.FIFO_DEPTH(DEPTH), .NUM_CELLS(NCELLS), .FILL_CHAR(FILL)) dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .cmd             (cw_if.slave),
      .clear_start     (clear_start),
      .busy            (busy),
      .instructionNum  (instructionNum),
      .instructionAddr (instructionAddr),
      .instructionData (instructionData),
      .instructionPrev (instructionPrev)
   );

   always #5 clock = ~clock;

   int          tests = 0;
   int          fails = 0;
   logic [17:0] exp_q[$];
   int          exp_num   = 0;
   logic [9:0]  last_num  = '0;
   logic [9:0]  last_addr = '0;
   logic [7:0]  last_data = '0;
   bit          mon_en    = 1'b0;
   bit          ack_en    = 1'b1;
   int          max_dly   = 0;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: a tag change is a new write, matched against the scoreboard.
   initial begin
      logic [17:0] e;
      forever begin
         @(negedge clock);
         if (mon_en && reset_n) begin
            if (instructionNum != last_num) begin
               exp_num = (exp_num + 1) % 1024;
               check("write_tag", int'(instructionNum), exp_num);
               if (exp_q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_write: actual addr=%0d data=%0d required=no write",
                           instructionAddr, instructionData);
               end else begin
                  e = exp_q.pop_front();
                  check("write_addr", int'(instructionAddr), int'(e[17:8]));
                  check("write_data", int'(instructionData), int'(e[7:0]));
               end
               last_num  = instructionNum;
               last_addr = instructionAddr;
               last_data = instructionData;
            end else begin
               check("hold_addr", int'(instructionAddr), int'(last_addr));
               check("hold_data", int'(instructionData), int'(last_data));
            end
         end
      end
   end

   // Display-stage model: takes each new tag after 0..max_dly cycles.
   initial begin
      int dly;
      dly = 0;
      forever begin
         @(negedge clock);
         if (ack_en && reset_n && (instructionPrev != instructionNum)) begin
            if (dly <= 0) begin
               instructionPrev = instructionNum;
               dly = int'($urandom_range(0, max_dly));
            end else begin
               dly--;
            end
         end
      end
   end

   task automatic do_reset();
      mon_en = 1'b0;
      @(negedge clock);
      reset_n         = 1'b0;
      cw_if.cmd_valid = 1'b0;
      clear_start     = 1'b0;
      instructionPrev = '0;
      @(negedge clock);
      check("rst_num",  int'(instructionNum), 0);
      check("rst_addr", int'(instructionAddr), 0);
      check("rst_data", int'(instructionData), 0);
      check("rst_busy", int'(busy), 0);
      exp_q.delete();
      exp_num   = 0;
      last_num  = '0;
      last_addr = '0;
      last_data = '0;
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      check("rst_ready", int'(cw_if.cmd_ready), 1);
      check("rst_busy_after", int'(busy), 0);
      mon_en = 1'b1;
   endtask

   // Offer one command; returns just after the transferring edge.
   task automatic send(input logic [9:0] a, input logic [7:0] d);
      int n;
      n = 0;
      @(negedge clock);
      cw_if.cmd_valid = 1'b1;
      cw_if.cmd_addr  = a;
      cw_if.cmd_data  = d;
      while (!cw_if.cmd_ready && n < 2000) begin
         @(negedge clock);
         n++;
      end
      if (cw_if.cmd_ready) begin
         exp_q.push_back({a, d});
         @(posedge clock);
      end else begin
         check("send_timeout", int'(cw_if.cmd_ready), 1);
      end
   endtask

   task automatic idle_bus();
      @(negedge clock);
      cw_if.cmd_valid = 1'b0;
   endtask

   task automatic pulse_clear(input bit expect_sweep);
      @(negedge clock);
      clear_start = 1'b1;
      if (expect_sweep)
         for (int c = 0; c < int'(NCELLS); c++) exp_q.push_back({10'(c), FILL});
      @(negedge clock);
      clear_start = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (!(exp_q.size() == 0 && !busy && instructionPrev == instructionNum) && n < 5000) begin
         @(negedge clock);
         n++;
      end
      check("idle_busy", int'(busy), 0);
      check("idle_drained", exp_q.size(), 0);
   endtask

   task automatic wait_queue_le(input int lim);
      int n;
      n = 0;
      while (exp_q.size() > lim && n < 500) begin
         @(negedge clock);
         n++;
      end
      check("queue_progress", int'(exp_q.size() <= lim), 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned gap;
      int          cnt;
      reset_n         = 1'b0;
      clear_start     = 1'b0;
      instructionPrev = '0;
      cw_if.cmd_valid = 1'b0;
      cw_if.cmd_addr  = '0;
      cw_if.cmd_data  = '0;
      do_reset();

      // Single write with prompt acknowledge.
      max_dly = 0;
      send(10'd5, 8'h41);
      idle_bus();
      wait_idle();
      check("single_num",  int'(instructionNum), 1);
      check("single_addr", int'(instructionAddr), 5);
      check("single_data", int'(instructionData), 'h41);

      // Burst into a full FIFO with the acknowledge withheld.
      do_reset();
      ack_en          = 1'b0;
      instructionPrev = 10'h3FF;
      for (int i = 0; i < int'(DEPTH); i++) send(10'(i * 7 + 1), 8'(8'h30 + i));
      @(negedge clock);
      check("full_ready", int'(cw_if.cmd_ready), 0);
      cw_if.cmd_addr = 10'd999;
      cw_if.cmd_data = 8'hFF;
      repeat (5) @(negedge clock);
      check("full_hold_ready", int'(cw_if.cmd_ready), 0);
      check("full_no_issue", int'(instructionNum), 0);
      cw_if.cmd_valid = 1'b0;
      instructionPrev = '0;
      ack_en          = 1'b1;
      max_dly         = 2;
      wait_idle();
      check("burst_num", int'(instructionNum), int'(DEPTH));

      // Random traffic up to 1023 writes, then the wrapping write.
      max_dly = 3;
      cnt     = int'(DEPTH);
      while (cnt < 1023) begin
         gap = $urandom_range(0, 2);
         if (gap != 0) begin
            idle_bus();
            repeat (gap - 1) @(negedge clock);
         end
         send(10'($urandom_range(0, 1023)), 8'($urandom_range(0, 255)));
         cnt++;
      end
      idle_bus();
      wait_idle();
      check("pre_wrap_num", int'(instructionNum), 1023);
      send(10'h3AB, 8'h5A);
      idle_bus();
      wait_idle();
      check("wrap_num",  int'(instructionNum), 0);
      check("wrap_addr", int'(instructionAddr), 'h3AB);

`ifdef CHAR_WRITER_CLEAR_EN
      // Clear from idle, then a queued command.
      pulse_clear(1'b1);
      send(10'd77, 8'hC3);
      idle_bus();
      wait_idle();
      check("clear_num",  int'(instructionNum), int'(NCELLS) + 1);
      check("clear_addr", int'(instructionAddr), 77);

      // Clear requested while a write is outstanding; second pulse mid-sweep.
      ack_en = 1'b0;
      send(10'd300, 8'h7E);
      idle_bus();
      wait_queue_le(0);
      pulse_clear(1'b1);
      repeat (6) @(negedge clock);
      check("clr_wait_addr", int'(instructionAddr), 300);
      check("clr_wait_busy", int'(busy), 1);
      ack_en = 1'b1;
      wait_queue_le(2);
      pulse_clear(1'b0);
      wait_idle();
      repeat (20) @(negedge clock);
      check("clr_mid_num", int'(instructionNum), 2 * int'(NCELLS) + 2);
      check("clr_mid_extra", exp_q.size(), 0);

      // Reset in the middle of a clear.
      pulse_clear(1'b1);
      wait_queue_le(2);
      do_reset();
`else
      // Clear requests are ignored in this build.
      pulse_clear(1'b0);
      repeat (20) @(negedge clock);
      check("noclr_num",  int'(instructionNum), 0);
      check("noclr_busy", int'(busy), 0);

      // Reset while a write is outstanding and more are queued.
      ack_en = 1'b0;
      send(10'd300, 8'h7E);
      send(10'd301, 8'h7F);
      idle_bus();
      wait_queue_le(1);
      do_reset();
      ack_en = 1'b1;
`endif
      repeat (30) @(negedge clock);
      check("post_rst_num",   int'(instructionNum), 0);
      check("post_rst_addr",  int'(instructionAddr), 0);
      check("post_rst_busy",  int'(busy), 0);
      check("post_rst_ready", int'(cw_if.cmd_ready), 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
